// File: rtl/feature_map_streamer_pkg.sv
// rtl/feature_map_streamer_pkg.sv - shared defaults, FSM state type and word width for the feature-map streamer
package feature_map_streamer_pkg;

  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_MAPS     = 6;
  localparam int DEF_SIZE     = 14;
  localparam int DEF_K        = 5;
  localparam int DEF_PIX_W    = DEF_IN_WIDTH * DEF_MAPS;
  localparam int ADDR_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/feature_map_streamer_ram.sv
// rtl/feature_map_streamer_ram.sv - frame store: one write port, one registered read port
//
// Ports:
//   clk, rst_n      clock, async active-low reset (clears only the read register)
//   we/waddr/wdata  synchronous write port
//   re/raddr        read request; rdata updates on the next edge when re=1
//   rdata           registered read data, holds while re=0
module frame_store_ram #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 196,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/feature_map_streamer.sv
// rtl/feature_map_streamer.sv - streams a stored multi-map frame in raster order and flags complete KxK windows
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   wr_en/wr_addr/wr_data  frame-store load, accepted only in IDLE or DONE
//   start                  begin streaming (IDLE only)
//   hold                   pause streaming
//   out, en                registered pixel word and its valid
//   win_valid              a KxK window completed with the previous pixel
//   win_row, win_col       window coordinates, held between pulses
//   busy, done             streaming / end-of-frame pulse
module feature_map_streamer
  import feature_map_streamer_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int MAPS     = DEF_MAPS,
  parameter int SIZE     = DEF_SIZE,
  parameter int K        = DEF_K
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [IN_WIDTH*MAPS-1:0] wr_data,
  input  logic                     start,
  input  logic                     hold,
  output logic [IN_WIDTH*MAPS-1:0] out,
  output logic                     en,
  output logic                     win_valid,
  output logic [3:0]               win_row,
  output logic [3:0]               win_col,
  output logic                     busy,
  output logic                     done
);

  localparam int PIX_W = IN_WIDTH * MAPS;
  localparam int NPIX  = SIZE * SIZE;
  localparam int CW    = $clog2(SIZE + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     row, col;        // next pixel to fetch; row reaches SIZE after the last one
  logic [CW-1:0]     em_row, em_col;  // coordinates of the pixel currently on out
  logic              adv;             // fetch-and-emit at this edge
  logic              we;
  logic [ADDR_W-1:0] rd_addr;
  logic              win_hit;

  assign we      = wr_en && (state == IDLE || state == DONE) && (wr_addr < ADDR_W'(NPIX));
  assign rd_addr = ADDR_W'(row * SIZE + col);
  assign win_hit = en && (em_row >= CW'(K - 1)) && (em_col >= CW'(K - 1));

  frame_store_ram #(
    .WIDTH (PIX_W),
    .DEPTH (NPIX),
    .AW    (ADDR_W)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (adv),
    .raddr (rd_addr),
    .rdata (out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The read for pixel 0 is issued on the same edge that samples start, so
  // out carries pixel k exactly k+1 cycles after start.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          adv       = 1'b1;
        end
      end
      STREAM: begin
        if (row == CW'(SIZE)) state_nxt = FLUSH;
        else if (!hold)       adv       = 1'b1;
      end
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == STREAM) || (state == FLUSH);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      em_row    <= '0;
      em_col    <= '0;
      en        <= 1'b0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      en <= adv;
      if (adv) begin
        em_row <= row;
        em_col <= col;
        if (col == CW'(SIZE - 1)) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (state == FLUSH) begin
        row <= '0;
        col <= '0;
      end
      win_valid <= win_hit;
      if (win_hit) begin
        win_row <= 4'(em_row - CW'(K - 1));
        win_col <= 4'(em_col - CW'(K - 1));
      end
    end
  end

endmodule

// File: tb/tb_feature_map_streamer.sv
// tb/tb_feature_map_streamer.sv - self-checking bench for feature_map_streamer
module tb_feature_map_streamer;
  import feature_map_streamer_pkg::*;

  localparam int PW = DEF_PIX_W;
  localparam int NC = 210;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [PW-1:0] out;
  logic          en, win_valid, busy, done;
  logic [3:0]    win_row, win_col;

  feature_map_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .hold      (hold),
    .out       (out),
    .en        (en),
    .win_valid (win_valid),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          s_en[NC], s_wv[NC], s_busy[NC], s_done[NC];
  logic [PW-1:0] s_out[NC];
  logic [3:0]    s_wr[NC], s_wc[NC];

  typedef struct {
    int         cyc;
    logic       en;
    int         pix;   // -1: out not checked
    logic       wv;
    int         wr;
    int         wc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [PW-1:0] pix(input int k);
    logic [PW-1:0] v;
    v = '0;
    for (int m = 0; m < 6; m++) v[8*m +: 8] = 8'((k + m) % 256);
    return v;
  endfunction

  task automatic chk(input string nm, input int c, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out"}, -1, 64'(out), 64'd0);
    chk({tag, " en"}, -1, 64'(en), 64'd0);
    chk({tag, " win_valid"}, -1, 64'(win_valid), 64'd0);
    chk({tag, " win_row"}, -1, 64'(win_row), 64'd0);
    chk({tag, " win_col"}, -1, 64'(win_col), 64'd0);
    chk({tag, " busy"}, -1, 64'(busy), 64'd0);
    chk({tag, " done"}, -1, 64'(done), 64'd0);
  endtask

  // Cycle c: inputs driven just after the edge opening it, outputs sampled at the falling edge.
  task automatic run(input int h0, input int h1, input int s2, input int wc);
    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      start   = (c == 0) || (c == s2);
      hold    = (c >= h0) && (c <= h1);
      wr_en   = (c == wc);
      wr_addr = '0;
      wr_data = '1;
      @(negedge clk);
      s_en[c] = en; s_out[c] = out; s_wv[c] = win_valid;
      s_wr[c] = win_row; s_wc[c] = win_col; s_busy[c] = busy; s_done[c] = done;
    end
    start = 1'b0; hold = 1'b0; wr_en = 1'b0;
  endtask

  task automatic check_model(input string tag, input int h0, input int h1, input int r0, input int c0);
    int hn, k, pk, lr, lc, ci, pulses, idx;
    logic ee, pe, ewv;
    logic [PW-1:0] cap[196];
    int sg, se;
    hn = (h0 < 0) ? 0 : h1 - h0 + 1;
    lr = r0; lc = c0; ci = 0; pulses = 0; pe = 1'b0; pk = 0;
    for (int c = 0; c < NC; c++) begin
      k = -1;
      if (c >= 1) begin
        if (hn == 0 || c <= h0) k = c - 1;
        else if (c > h1 + 1)    k = c - 1 - hn;
        if (k > 195) k = -1;
      end
      ee = (k >= 0);
      chk({tag, " en"}, c, 64'(s_en[c]), 64'(ee));
      if (ee) chk({tag, " out"}, c, 64'(s_out[c]), 64'(pix(k)));
      else if (hn > 0 && c > h0 && c <= h1 + 1) chk({tag, " out_frozen"}, c, 64'(s_out[c]), 64'(pix(h0 - 1)));
      ewv = pe && (pk / 14 >= 4) && (pk % 14 >= 4);
      if (ewv) begin lr = pk / 14 - 4; lc = pk % 14 - 4; end
      chk({tag, " win_valid"}, c, 64'(s_wv[c]), 64'(ewv));
      chk({tag, " win_row"}, c, 64'(s_wr[c]), 64'(lr));
      chk({tag, " win_col"}, c, 64'(s_wc[c]), 64'(lc));
      chk({tag, " busy"}, c, 64'(s_busy[c]), 64'(c >= 1 && c <= 197 + hn));
      chk({tag, " done"}, c, 64'(s_done[c]), 64'(c == 198 + hn));
      if (s_en[c] === 1'b1 && ci < 196) begin cap[ci] = s_out[c]; ci++; end
      // Window scoreboard: per-map 5x5 sums over the streamed pixels vs the loaded frame.
      if (s_wv[c] === 1'b1) begin
        pulses++;
        for (int m = 0; m < 6; m++) begin
          sg = 0; se = 0;
          for (int dr = 0; dr < 5; dr++)
            for (int dc = 0; dc < 5; dc++) begin
              idx = (int'(s_wr[c]) + dr) * 14 + int'(s_wc[c]) + dc;
              if (idx < ci) sg += int'(cap[idx][8*m +: 8]);
              else          sg -= 100000;
              se += (idx + m) % 256;
            end
          chk({tag, " window_sum"}, c, 64'(sg), 64'(se));
        end
      end
      pe = ee; pk = k;
    end
    chk({tag, " pulses"}, -1, 64'(pulses), 64'd100);
  endtask

  initial begin
    tbl[0] = '{0,   1'b0, -1,  1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1] = '{1,   1'b1, 0,   1'b0, 0, 0, 1'b1, 1'b0};
    tbl[2] = '{61,  1'b1, 60,  1'b0, 0, 0, 1'b1, 1'b0};
    tbl[3] = '{62,  1'b1, 61,  1'b1, 0, 0, 1'b1, 1'b0};
    tbl[4] = '{63,  1'b1, 62,  1'b1, 0, 1, 1'b1, 1'b0};
    tbl[5] = '{76,  1'b1, 75,  1'b1, 1, 0, 1'b1, 1'b0};
    tbl[6] = '{196, 1'b1, 195, 1'b1, 9, 8, 1'b1, 1'b0};
    tbl[7] = '{197, 1'b0, -1,  1'b1, 9, 9, 1'b1, 1'b0};
    tbl[8] = '{198, 1'b0, -1,  1'b0, 9, 9, 1'b0, 1'b1};
    tbl[9] = '{199, 1'b0, -1,  1'b0, 9, 9, 1'b0, 1'b0};

    #12;
    chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 196; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 8'(k); wr_data = pix(k);
    end
    @(posedge clk); #1;
    wr_addr = 8'd200; wr_data = '1;
    @(posedge clk); #1 wr_en = 1'b0;

    // Plain frame: hand-computed spot checks, then the full model.
    run(-1, -1, -1, -1);
    chk("pixel0_literal", 1, 64'(s_out[1]), 64'h0000_0504_0302_0100);
    for (int i = 0; i < 10; i++) begin
      chk("tbl en", tbl[i].cyc, 64'(s_en[tbl[i].cyc]), 64'(tbl[i].en));
      if (tbl[i].pix >= 0) chk("tbl out", tbl[i].cyc, 64'(s_out[tbl[i].cyc]), 64'(pix(tbl[i].pix)));
      chk("tbl win_valid", tbl[i].cyc, 64'(s_wv[tbl[i].cyc]), 64'(tbl[i].wv));
      chk("tbl win_row", tbl[i].cyc, 64'(s_wr[tbl[i].cyc]), 64'(tbl[i].wr));
      chk("tbl win_col", tbl[i].cyc, 64'(s_wc[tbl[i].cyc]), 64'(tbl[i].wc));
      chk("tbl busy", tbl[i].cyc, 64'(s_busy[tbl[i].cyc]), 64'(tbl[i].busy));
      chk("tbl done", tbl[i].cyc, 64'(s_done[tbl[i].cyc]), 64'(tbl[i].done));
    end
    check_model("plain", -1, -1, 0, 0);

    run(10, 14, -1, -1);
    check_model("hold", 10, 14, 9, 9);

    run(-1, -1, 50, 50);
    check_model("restart_wr", -1, -1, 9, 9);

    // Mid-stream reset: outputs clear at once, no done afterwards.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1 start = (c == 0);
    end
    start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_reset done", c, 64'(done), 64'd0);
      chk("post_reset busy", c, 64'(busy), 64'd0);
    end

    run(-1, -1, -1, -1);
    check_model("fresh", -1, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
